// File: rtl/video_pkg.sv
// Shared video-path types: packed RGB entry, palette loader state encoding
// and the palette size.
package video_pkg;

    localparam int PAL_ENTRIES = 64;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    typedef enum logic [1:0] {
        PL_IDLE,
        PL_LOAD,
        PL_DRAIN,
        PL_DONE
    } pl_state_e;

    // The first two bytes of an entry sit in the packer as {R,G}; the third byte is blue.
    function automatic rgb24_t pack_rgb(input logic [15:0] rg, input logic [7:0] blue);
        rgb24_t v;
        v.r = rg[15:8];
        v.g = rg[7:0];
        v.b = blue;
        return v;
    endfunction

endpackage

// File: rtl/pl_sync_fifo.sv
// Small synchronous staging FIFO with flush, occupancy count and a
// combinational head read.
module pl_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/palette_loader.sv
// Packs ioctl palette bytes into RGB entries and commits them to the palette
// RAM during vblank. Define PALETTE_LOADER_CHECKSUM_EN to add a byte checksum output.
module palette_loader
    import video_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 4,
    parameter int         NUM_ENTRIES = PAL_ENTRIES,
    parameter bit         VBLANK_ONLY = 1'b1,
    parameter logic [7:0] PAL_INDEX   = 8'h03
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    input  logic        vblank,
    output logic        load_color,
    output logic [23:0] load_color_data,
    output logic [5:0]  load_color_index,
    output logic        busy,
    output logic        done,
    output logic        error
`ifdef PALETTE_LOADER_CHECKSUM_EN
    ,
    output logic [7:0]  checksum
`endif
);

    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int EW    = $clog2(NUM_ENTRIES + 1);
    localparam int IDX_W = 6;

    pl_state_e          r_state;
    logic               r_sel_prev;
    logic [1:0]         r_phase;
    logic [15:0]        r_packer;
    logic [EW-1:0]      r_entry_cnt;
    logic               r_push_pend;
    rgb24_t             r_push_data;
    logic [IDX_W-1:0]   r_wr_idx;
    logic               r_load_color;
    logic [23:0]        r_color_data;
    logic [IDX_W-1:0]   r_color_index;
    logic               r_done;
    logic               r_error;
`ifdef PALETTE_LOADER_CHECKSUM_EN
    logic [7:0]         r_checksum;
`endif

    logic               w_sel;
    logic               w_sel_rise;
    logic               w_active;
    logic               w_flush;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [CW-1:0]      w_count;
    logic [23:0]        w_pop_data;
    logic               w_wr_load;
    logic               w_drop;

    assign w_sel      = ioctl_download && (ioctl_index == PAL_INDEX);
    assign w_sel_rise = w_sel && !r_sel_prev;
    assign w_active   = (r_state == PL_LOAD) || (r_state == PL_DRAIN);
    assign w_flush    = (r_state == PL_IDLE) && w_sel_rise;
    assign w_pop      = w_active && !w_empty && (vblank || !VBLANK_ONLY);
    assign w_wr_load  = (r_state == PL_LOAD) && w_sel && ioctl_wr;
    assign w_drop     = w_wr_load && ((r_entry_cnt == EW'(NUM_ENTRIES)) || w_full);

    pl_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (24)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_flush     (w_flush),
        .i_push      (r_push_pend),
        .i_push_data (r_push_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_pop_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    // One slot of slack covers a phase-2 byte already in flight when wait rises.
    assign ioctl_wait       = (w_count >= CW'(FIFO_DEPTH - 1));
    assign load_color       = r_load_color;
    assign load_color_data  = r_color_data;
    assign load_color_index = r_color_index;
    assign busy             = (r_state != PL_IDLE);
    assign done             = r_done;
    assign error            = r_error;
`ifdef PALETTE_LOADER_CHECKSUM_EN
    assign checksum         = r_checksum;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= PL_IDLE;
            r_sel_prev    <= 1'b0;
            r_phase       <= '0;
            r_packer      <= '0;
            r_entry_cnt   <= '0;
            r_push_pend   <= 1'b0;
            r_push_data   <= '0;
            r_wr_idx      <= '0;
            r_load_color  <= 1'b0;
            r_color_data  <= '0;
            r_color_index <= '0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
`ifdef PALETTE_LOADER_CHECKSUM_EN
            r_checksum    <= '0;
`endif
        end else begin
            r_sel_prev   <= w_sel;
            r_load_color <= 1'b0;
            r_done       <= 1'b0;
            r_push_pend  <= 1'b0;

            if (w_pop) begin
                r_load_color  <= 1'b1;
                r_color_data  <= w_pop_data;
                r_color_index <= r_wr_idx;
                if (r_wr_idx != IDX_W'(NUM_ENTRIES - 1)) begin
                    r_wr_idx <= r_wr_idx + 1'b1;
                end
            end

            // A pending push that finds no room is lost; only a non-compliant HPS gets here.
            if (r_push_pend && w_full && !w_pop) begin
                r_error <= 1'b1;
            end

            case (r_state)
                PL_IDLE: begin
                    if (w_sel_rise) begin
                        r_state     <= PL_LOAD;
                        r_error     <= 1'b0;
                        r_phase     <= '0;
                        r_entry_cnt <= '0;
                        r_wr_idx    <= '0;
`ifdef PALETTE_LOADER_CHECKSUM_EN
                        r_checksum  <= '0;
`endif
                    end
                end
                PL_LOAD: begin
                    if (!w_sel) begin
                        r_state <= PL_DRAIN;
                        r_phase <= '0;
                        if (r_phase != 2'd0) begin
                            r_error <= 1'b1;
                        end
                    end else if (w_drop) begin
                        r_error <= 1'b1;
                    end else if (w_wr_load) begin
`ifdef PALETTE_LOADER_CHECKSUM_EN
                        r_checksum <= r_checksum + ioctl_dout;
`endif
                        if (r_phase == 2'd2) begin
                            r_push_pend <= 1'b1;
                            r_push_data <= pack_rgb(r_packer, ioctl_dout);
                            r_phase     <= '0;
                            r_entry_cnt <= r_entry_cnt + 1'b1;
                        end else begin
                            r_packer <= {r_packer[7:0], ioctl_dout};
                            r_phase  <= r_phase + 1'b1;
                        end
                    end
                end
                PL_DRAIN: begin
                    if (w_empty && !r_load_color && !r_push_pend) begin
                        r_state <= PL_DONE;
                        r_done  <= 1'b1;
                    end
                end
                PL_DONE: begin
                    r_state <= PL_IDLE;
                end
                default: begin
                    r_state <= PL_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_palette_loader.sv
// Scoreboard bench for palette_loader: stimulus pushes expected palette writes,
// a negedge monitor pops and compares them as load_color pulses appear.
module tb_palette_loader;

    localparam logic [7:0] PAL_IDX = 8'h03;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'h00;
    logic        ioctl_wr = 1'b0;
    logic [7:0]  ioctl_dout = 8'h00;
    logic        vblank = 1'b0;
    logic        ioctl_wait;
    logic        load_color;
    logic [23:0] load_color_data;
    logic [5:0]  load_color_index;
    logic        busy;
    logic        done;
    logic        error;
`ifdef PALETTE_LOADER_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    int          n_checks = 0;
    int          n_pass = 0;
    int          commit_cnt = 0;
    int          done_cnt = 0;
    int          max_idx = 0;
    logic [29:0] exp_q[$];
    bit          vb_rand = 1'b0;

    always #5 clk = ~clk;

    palette_loader dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .ioctl_download   (ioctl_download),
        .ioctl_index      (ioctl_index),
        .ioctl_wr         (ioctl_wr),
        .ioctl_dout       (ioctl_dout),
        .ioctl_wait       (ioctl_wait),
        .vblank           (vblank),
        .load_color       (load_color),
        .load_color_data  (load_color_data),
        .load_color_index (load_color_index),
        .busy             (busy),
        .done             (done),
        .error            (error)
`ifdef PALETTE_LOADER_CHECKSUM_EN
        ,
        .checksum         (checksum)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (reset_n && load_color) begin
            commit_cnt++;
            if (int'(load_color_index) > max_idx) max_idx = int'(load_color_index);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_commit: got idx %0d data 0x%06h, expected no write",
                         load_color_index, load_color_data);
            end else begin
                logic [29:0] e;
                e = exp_q.pop_front();
                check("commit", {2'b00, load_color_index, load_color_data}, {2'b00, e});
            end
        end
        if (reset_n && done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (vb_rand) vblank = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit honor);
        int guard = 0;
        while (honor && ioctl_wait && guard < 2000) begin
            step();
            guard++;
        end
        if (guard >= 2000) check("wait_release_timeout", {31'd0, ioctl_wait}, 32'd0);
        ioctl_dout = b;
        ioctl_wr   = 1'b1;
        step();
        ioctl_wr   = 1'b0;
        repeat ($urandom_range(0, 1)) step();
    endtask

    task automatic wait_done(input int d0, input string tag);
        int guard = 0;
        while (done_cnt == d0 && guard < 5000) begin
            step();
            guard++;
        end
        step();
        step();
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
    endtask

    task automatic push_model(input logic [7:0] bytes[$]);
        int ents = bytes.size() / 3;
        if (ents > 64) ents = 64;
        for (int k = 0; k < ents; k++)
            exp_q.push_back({6'(k), bytes[3*k], bytes[3*k+1], bytes[3*k+2]});
    endtask

    task automatic run_load(input logic [7:0] bytes[$], input string tag);
        int         n = bytes.size();
        int         ents = (n / 3 > 64) ? 64 : n / 3;
        int         c0 = commit_cnt;
        int         d0 = done_cnt;
        logic [7:0] sum = 8'h00;
        for (int i = 0; i < n && i < 192; i++) sum = sum + bytes[i];
        push_model(bytes);
        ioctl_index    = PAL_IDX;
        ioctl_download = 1'b1;
        step();
        step();
        foreach (bytes[i]) send_byte(bytes[i], 1'b1);
        ioctl_download = 1'b0;
        wait_done(d0, tag);
        check({tag, "_commits"}, commit_cnt - c0, ents);
        check({tag, "_error"}, {31'd0, error}, {31'd0, (n % 3 != 0) || (n > 192)});
        check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
`ifdef PALETTE_LOADER_CHECKSUM_EN
        check({tag, "_checksum"}, {24'd0, checksum}, {24'd0, sum});
`endif
        $display("load %s: %0d bytes, %0d writes, error=%0b", tag, n, commit_cnt - c0, error);
    endtask

    initial begin
        logic [7:0] q[$];
        int         c0;
        int         d0;
        int         guard;

        #1;
        check("rst_load_color", {31'd0, load_color}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_error", {31'd0, error}, 0);
        check("rst_wait", {31'd0, ioctl_wait}, 0);
        check("rst_data_idx", {2'b00, load_color_index, load_color_data}, 0);
        repeat (3) step();
        reset_n = 1'b1;
        step();
        check("idle_busy", {31'd0, busy}, 0);

        // Nominal: entry k = {k, ~k, k<<2}, vblank constantly high.
        vblank = 1'b1;
        q = {};
        for (int k = 0; k < 64; k++) begin
            logic [7:0] kb;
            kb = 8'(k);
            q.push_back(kb);
            q.push_back(kb ^ 8'hFF);
            q.push_back(8'(kb << 2));
        end
        max_idx = 0;
        run_load(q, "nominal");
        check("nominal_max_idx", max_idx, 63);

        // Vblank gating with the FIFO filling up.
        vblank = 1'b0;
        q = {};
        for (int i = 0; i < 12; i++) q.push_back(8'($urandom));
        push_model(q);
        c0 = commit_cnt;
        d0 = done_cnt;
        ioctl_index    = PAL_IDX;
        ioctl_download = 1'b1;
        step();
        step();
        for (int i = 0; i < 6; i++) send_byte(q[i], 1'b0);
        step();
        step();
        check("gate_wait_at2", {31'd0, ioctl_wait}, 0);
        for (int i = 6; i < 9; i++) send_byte(q[i], 1'b0);
        step();
        step();
        check("gate_wait_at3", {31'd0, ioctl_wait}, 1);
        for (int i = 9; i < 12; i++) send_byte(q[i], 1'b0);
        repeat (3) step();
        check("gate_no_commit", commit_cnt - c0, 0);
        check("gate_wait_full", {31'd0, ioctl_wait}, 1);
        check("gate_error", {31'd0, error}, 0);
        vblank = 1'b1;
        guard = 0;
        while (commit_cnt - c0 < 4 && guard < 50) begin
            step();
            guard++;
        end
        step();
        check("gate_commits", commit_cnt - c0, 4);
        check("gate_wait_release", {31'd0, ioctl_wait}, 0);
        ioctl_download = 1'b0;
        wait_done(d0, "gate");
        check("gate_error_end", {31'd0, error}, 0);
        $display("load gate: 12 bytes, %0d writes, error=%0b", commit_cnt - c0, error);

        // Short file: partial third entry.
        q = {};
        for (int i = 0; i < 7; i++) q.push_back(8'($urandom));
        run_load(q, "short");

        // Wrong download target must be ignored.
        c0 = commit_cnt;
        ioctl_index    = 8'h05;
        ioctl_download = 1'b1;
        step();
        step();
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b0);
        check("other_idx_busy", {31'd0, busy}, 0);
        check("other_idx_commits", commit_cnt - c0, 0);
        ioctl_download = 1'b0;
        step();

        // Overlong file.
        q = {};
        for (int i = 0; i < 195; i++) q.push_back(8'($urandom));
        max_idx = 0;
        run_load(q, "overlong");
        check("overlong_max_idx", max_idx, 63);

        // Random lengths with random vblank gating.
        vb_rand = 1'b1;
        for (int t = 0; t < 4; t++) begin
            q = {};
            for (int i = 0; i < int'($urandom_range(3, 60)); i++) q.push_back(8'($urandom));
            run_load(q, "random");
        end
        vb_rand = 1'b0;

        // Asynchronous reset after entry 10 has been written.
        vblank = 1'b1;
        q = {};
        for (int i = 0; i < 33; i++) q.push_back(8'($urandom));
        push_model(q);
        c0 = commit_cnt;
        ioctl_index    = PAL_IDX;
        ioctl_download = 1'b1;
        step();
        step();
        foreach (q[i]) send_byte(q[i], 1'b1);
        guard = 0;
        while (commit_cnt - c0 < 11 && guard < 100) begin
            step();
            guard++;
        end
        vblank = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b1);
        check("arst_pre_commits", commit_cnt - c0, 11);
        check("arst_pre_busy", {31'd0, busy}, 1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 0);
        check("arst_load_color", {31'd0, load_color}, 0);
        check("arst_done_error", {30'd0, done, error}, 0);
        check("arst_data_idx", {2'b00, load_color_index, load_color_data}, 0);
        check("arst_wait", {31'd0, ioctl_wait}, 0);
        vblank = 1'b1;
        repeat (5) step();
        check("arst_no_more_commits", commit_cnt - c0, 11);
        ioctl_download = 1'b0;
        reset_n = 1'b1;
        step();
        q = {};
        for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
        max_idx = 0;
        run_load(q, "after_reset");
        check("after_reset_max_idx", max_idx, 1);

`ifdef PALETTE_LOADER_CHECKSUM_EN
        q = {8'hFF, 8'hFF, 8'hFF};
        run_load(q, "cksum");
        check("cksum_ff", {24'd0, checksum}, 32'h0000_00FD);
`endif

        step();
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
